// File: rtl/serial_adder_if.sv
// ============================================================================
// Module   : serial_adder_if
// Purpose  : Start/ready request and result bundle for serial_adder.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );
endinterface

`default_nettype wire

// File: rtl/serial_adder.sv
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial WIDTH-bit adder, one full-adder step per clock, LSB first.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  wire           clk,
  input  wire           rst_n,
  serial_adder_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] K_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [CW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic bit_a, bit_b, bit_s, bit_c;

  assign bit_a = a_q[k_q];
  assign bit_b = b_q[k_q];
  assign bit_s = bit_a ^ bit_b ^ c_q;
  assign bit_c = (bit_a & bit_b) | (bit_a & c_q) | (bit_b & c_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      k_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      k_q     <= k_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    k_d     = k_q;
    res_d   = res_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          c_d     = bus.cin;
          k_d     = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        res_d[k_q] = bit_s;
        c_d        = bit_c;
        k_d        = k_q + CW'(1);
        // Outputs are only published here, so no partial sum is ever visible.
        if (k_q == K_LAST) begin
          state_d = S_DONE;
          sum_d   = res_d;
          cout_d  = bit_c;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ready = (state_q == S_IDLE);
  assign bus.busy  = (state_q == S_ADD);
  assign bus.done  = (state_q == S_DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed self-checking bench for serial_adder at WIDTH=8 and WIDTH=1.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_adder;

  logic clk;
  logic rst_n;

  serial_adder_if #(.WIDTH(8)) i8 ();
  serial_adder_if #(.WIDTH(1)) i1 ();

  serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
  serial_adder #(.WIDTH(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int excl_err = 0;
  logic mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if ($countones({i8.ready, i8.busy, i8.done}) != 1) excl_err++;
      if ($countones({i1.ready, i1.busy, i1.done}) != 1) excl_err++;
    end
  end

  // One 8-bit operation; hold keeps start high and scrambles a during ADD.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic [7:0] es, input logic ec, input bit hold);
    int n;
    bit held;
    logic [7:0] psum;
    logic pcout;
    psum  = i8.sum;
    pcout = i8.cout;
    held  = 1'b1;
    @(negedge clk);
    i8.start = 1'b1; i8.a = a; i8.b = b; i8.cin = c;
    @(negedge clk);
    if (!hold) i8.start = 1'b0;
    n = 0;
    while (!i8.done && n < 20) begin
      if (i8.sum !== psum || i8.cout !== pcout) held = 1'b0;
      if (hold) begin i8.a = 8'hF0; i8.b = 8'h33; i8.cin = 1'b1; end
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_sum"}, i8.sum, es);
    check({tag, "_cout"}, i8.cout, ec);
    check({tag, "_held"}, held, 1);
    i8.start = 1'b0;
    @(negedge clk);
    check({tag, "_ready_back"}, {i8.ready, i8.busy, i8.done}, 3'b100);
  endtask

  initial begin
    logic [7:0] tt_sum;
    logic [7:0] tt_cout;
    int n;
    bit nodone;
    tt_sum  = 8'b1001_0110;
    tt_cout = 8'b1110_1000;

    i8.start = 1'b0; i8.a = '0; i8.b = '0; i8.cin = 1'b0;
    i1.start = 1'b0; i1.a = '0; i1.b = '0; i1.cin = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_flags", {i8.ready, i8.busy, i8.done}, 3'b100);
    check("reset_result", {i8.cout, i8.sum}, 9'h000);
    rst_n = 1'b1;
    mon_en = 1'b1;

    op8("t1", 8'h69, 8'h17, 1'b0, 8'h80, 1'b0, 1'b0);
    op8("t2a", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    op8("t2b", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8("t3", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1);
    @(negedge clk);
    check("t3_no_restart", {i8.ready, i8.busy}, 2'b10);

    // Abort in the 4th ADD cycle.
    @(negedge clk);
    i8.start = 1'b1; i8.a = 8'hAA; i8.b = 8'h55; i8.cin = 1'b1;
    @(negedge clk);
    i8.start = 1'b0;
    repeat (3) @(negedge clk);
    check("t4_busy_before", i8.busy, 1);
    rst_n = 1'b0;
    #1;
    check("t4_flags", {i8.ready, i8.busy, i8.done}, 3'b100);
    check("t4_result", {i8.cout, i8.sum}, 9'h000);
    @(negedge clk);
    rst_n = 1'b1;
    nodone = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (i8.done || !i8.ready) nodone = 1'b0;
    end
    check("t4_no_done", nodone, 1);
    op8("t4_fresh", 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b0);

    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {i1.a, i1.b, i1.cin} = i[2:0];
      i1.start = 1'b1;
      @(negedge clk);
      i1.start = 1'b0;
      n = 0;
      while (!i1.done && n < 10) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("t5_lat_%0d", i), n, 1);
      check($sformatf("t5_fa_%0d", i), {i1.cout, i1.sum}, {tt_cout[i], tt_sum[i]});
    end

    @(negedge clk);
    check("exclusive_flags", excl_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
